// File: rtl/shifter_seq_ctrl.sv
// Sequencer for a universal shift register: takes a load/shift command, paces N shifts
// at a programmable bit period and hands back the final shifter word.
module shifter_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic             i_cmd_load,
   input  logic             i_cmd_dir,
   input  logic [CNT_W-1:0] i_cmd_len,
   input  logic [DIV_W-1:0] i_cmd_div,
   input  logic [WIDTH-1:0] i_cmd_pdata,
   input  logic             i_abort,
   output logic [1:0]       o_sh_select,
   output logic [WIDTH-1:0] o_sh_pdata,
   output logic             o_sh_sdata_rt,
   output logic             o_sh_sdata_lt,
   input  logic [WIDTH-1:0] i_sh_pdata,
   input  logic             i_ser_in,
   output logic             o_ser_out,
   output logic             o_bit_strobe,
   output logic             o_busy,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_pdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

   // Zero and out-of-range counts both mean a full-width shift.
   function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] len);
      if (len == '0 || len > LEN_MAX) return LEN_MAX;
      return len;
   endfunction

   state_t           state, state_nxt;
   logic             accept;
   logic             dir_r;
   logic [CNT_W-1:0] len_r;
   logic [DIV_W-1:0] div_r;
   logic [WIDTH-1:0] pdata_r;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] bit_cnt_inc;
   logic [DIV_W-1:0] wait_cnt;
   logic [WIDTH-1:0] rsp_pdata_r;
   logic             rsp_cap;
   logic             last_shift;

   assign accept      = i_cmd_valid && (state == S_IDLE);
   assign bit_cnt_inc = bit_cnt + CNT_W'(1);
   assign last_shift  = (bit_cnt_inc == len_r);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         rsp_cap     <= 1'b0;
         rsp_pdata_r <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE)
            bit_cnt <= '0;
         else if (state == S_SHIFT && !i_abort)
            bit_cnt <= bit_cnt_inc;
         // Reloaded every non-WAIT cycle so it is primed on whichever edge enters WAIT.
         if (state != S_WAIT)
            wait_cnt <= ((state == S_IDLE) ? i_cmd_div : div_r) - DIV_W'(1);
         else
            wait_cnt <= wait_cnt - DIV_W'(1);
         rsp_cap <= (state == S_DONE);
         if (state == S_DONE && !rsp_cap)
            rsp_pdata_r <= i_sh_pdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         dir_r   <= i_cmd_dir;
         len_r   <= norm_len(i_cmd_len);
         div_r   <= i_cmd_div;
         pdata_r <= i_cmd_pdata;
      end
   end

   always_comb begin
      state_nxt    = state;
      o_sh_select  = 2'b00;
      o_bit_strobe = 1'b0;
      o_rsp_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_cmd_valid) begin
               if (i_cmd_load)          state_nxt = S_LOAD;
               else if (i_cmd_div == '0) state_nxt = S_SHIFT;
               else                     state_nxt = S_WAIT;
            end
         end
         S_LOAD: begin
            o_sh_select = 2'b11;
            state_nxt   = (div_r == '0) ? S_SHIFT : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == '0) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            o_sh_select  = dir_r ? 2'b10 : 2'b01;
            o_bit_strobe = 1'b1;
            if (last_shift)          state_nxt = S_DONE;
            else if (div_r == '0)    state_nxt = S_SHIFT;
            else                     state_nxt = S_WAIT;
         end
         S_DONE: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort freezes the shifter in the same cycle and discards any response.
      if (i_abort && state != S_IDLE) begin
         state_nxt    = S_IDLE;
         o_sh_select  = 2'b00;
         o_bit_strobe = 1'b0;
         o_rsp_valid  = 1'b0;
      end
   end

   assign o_cmd_ready   = (state == S_IDLE);
   assign o_busy        = (state != S_IDLE);
   assign o_sh_pdata    = (state == S_LOAD) ? pdata_r : '0;
   assign o_sh_sdata_rt = o_busy & ~dir_r & i_ser_in;
   assign o_sh_sdata_lt = o_busy &  dir_r & i_ser_in;
   assign o_ser_out     = o_busy & (dir_r ? i_sh_pdata[WIDTH-1] : i_sh_pdata[0]);
   // First DONE cycle passes the settled shifter word through while the register captures it.
   assign o_rsp_pdata   = (state == S_DONE && !rsp_cap) ? i_sh_pdata : rsp_pdata_r;

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// Scoreboard bench for shifter_seq_ctrl paired with a behavioural universal shifter.
module tb_shifter_seq_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int DIV_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0, cmd_dir = 1'b0;
   logic [CNT_W-1:0] cmd_len = '0;
   logic [DIV_W-1:0] cmd_div = '0;
   logic [WIDTH-1:0] cmd_pdata = '0;
   logic             abort = 1'b0;
   logic [1:0]       sel;
   logic [WIDTH-1:0] sh_pdata_o, sh;
   logic             sdata_rt, sdata_lt;
   logic             ser_in = 1'b0, ser_out, strobe, busy, rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_pdata;

   shifter_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_load(cmd_load), .i_cmd_dir(cmd_dir), .i_cmd_len(cmd_len),
      .i_cmd_div(cmd_div), .i_cmd_pdata(cmd_pdata), .i_abort(abort),
      .o_sh_select(sel), .o_sh_pdata(sh_pdata_o),
      .o_sh_sdata_rt(sdata_rt), .o_sh_sdata_lt(sdata_lt),
      .i_sh_pdata(sh), .i_ser_in(ser_in), .o_ser_out(ser_out),
      .o_bit_strobe(strobe), .o_busy(busy),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_pdata(rsp_pdata)
   );

   // Behavioural universal shifter sharing the controller reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '0;
      else begin
         case (sel)
            2'b01:   sh <= {sdata_rt, sh[WIDTH-1:1]};
            2'b10:   sh <= {sh[WIDTH-2:0], sdata_lt};
            2'b11:   sh <= sh_pdata_o;
            default: sh <= sh;
         endcase
      end
   end

   int checks = 0;
   int failures = 0;
   logic [WIDTH-1:0] exp_q[$];

   int   sel_log[64];
   logic strb_log[64];
   logic sout_log[64];
   bit   ser_pat[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every handshake
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got %0h expected no response", rsp_pdata);
         end else begin
            chk("rsp_pdata", rsp_pdata, exp_q.pop_front());
         end
      end
   end

   // Shift selects appear exactly when the strobe does; busy mirrors not-ready
   always @(negedge clk) begin
      if (rst_n) begin
         chk("sel_vs_strobe", 32'((sel == 2'b01) || (sel == 2'b10)), 32'(strobe));
         chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sel"}, sel, 2'b00);
      chk({tag, "_sh_pdata"}, sh_pdata_o, 8'h00);
      chk({tag, "_strobe"}, strobe, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_pdata"}, rsp_pdata, 8'h00);
      chk({tag, "_ser_out"}, ser_out, 1'b0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
   endtask

   task automatic send_cmd(input logic ld, input logic dr, input logic [CNT_W-1:0] len,
                           input logic [DIV_W-1:0] dv, input logic [WIDTH-1:0] pd);
      bit got = 0;
      @(posedge clk); #1;
      cmd_load = ld; cmd_dir = dr; cmd_len = len; cmd_div = dv; cmd_pdata = pd;
      cmd_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1; break; end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic ld, input logic dr, input logic [CNT_W-1:0] len,
                          input logic [DIV_W-1:0] dv, input logic [WIDTH-1:0] pd,
                          input logic [WIDTH-1:0] exp, output int rv_cyc, output int nstb);
      exp_q.push_back(exp);
      send_cmd(ld, dr, len, dv, pd);
      rv_cyc = -1;
      nstb = 0;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         sel_log[k] = int'(sel);
         strb_log[k] = strobe;
         sout_log[k] = ser_out;
         if (strobe) begin
            ser_in = ser_pat[nstb % 16];
            nstb++;
         end
         if (rsp_valid) begin rv_cyc = k; break; end
      end
      if (rv_cyc < 0) begin
         checks++;
         failures++;
         $display("FAIL rsp_timeout: got no rsp_valid expected one within 63 cycles");
      end
   endtask

   initial begin
      int rv, ns, cnt, rcnt;
      logic [7:0] so;
      logic [31:0] mask;
      logic [7:0] pat2;

      for (int i = 0; i < 16; i++) ser_pat[i] = 1'b0;
      #12;
      check_reset_outputs("reset");
      #5 rst_n = 1'b1;

      // 1: load A5, right shift 8, back-to-back
      run_cmd(1'b1, 1'b0, 4'd8, 8'd0, 8'hA5, 8'h00, rv, ns);
      chk("t1_sel_load", sel_log[1], 3);
      for (int k = 2; k <= 9; k++) chk("t1_sel_shift", sel_log[k], 1);
      for (int k = 2; k <= 9; k++) so[k-2] = sout_log[k];
      chk("t1_ser_out", so, 8'hA5);
      chk("t1_rsp_cycle", rv, 10);
      chk("t1_nshift", ns, 8);

      // 2: no load, left shift 8, div 3, serial pattern in
      pat2 = 8'b01010011;
      for (int i = 0; i < 8; i++) ser_pat[i] = pat2[i];
      run_cmd(1'b0, 1'b1, 4'd8, 8'd3, 8'h00, 8'hCA, rv, ns);
      mask = '0;
      for (int k = 1; k <= 32; k++) mask[k-1] = strb_log[k];
      chk("t2_strobe_pattern", mask, 32'h88888888);
      chk("t2_sel_left", sel_log[4], 2);
      chk("t2_rsp_cycle", rv, 33);
      for (int i = 0; i < 16; i++) ser_pat[i] = 1'b0;
      @(posedge clk); #1 ser_in = 1'b0;

      // 3: partial length, zero length, oversize length
      run_cmd(1'b1, 1'b0, 4'd3, 8'd0, 8'hFF, 8'h1F, rv, ns);
      chk("t3_nshift_len3", ns, 3);
      chk("t3_rsp_cycle_len3", rv, 5);
      run_cmd(1'b1, 1'b0, 4'd0, 8'd0, 8'hFF, 8'h00, rv, ns);
      chk("t3_nshift_len0", ns, 8);
      chk("t3_rsp_cycle_len0", rv, 10);
      run_cmd(1'b1, 1'b1, 4'd15, 8'd0, 8'h81, 8'h00, rv, ns);
      chk("t3_nshift_len15", ns, 8);

      // 4: response back-pressure
      @(posedge clk); #1 rsp_ready = 1'b0;
      run_cmd(1'b1, 1'b0, 4'd2, 8'd0, 8'h3C, 8'h0F, rv, ns);
      chk("t4_rsp_cycle", rv, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", rsp_valid, 1'b1);
         chk("t4_hold_pdata", rsp_pdata, 8'h0F);
         chk("t4_hold_sel", sel, 2'b00);
         chk("t4_hold_cmd_ready", cmd_ready, 1'b0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("t4_idle_ready", cmd_ready, 1'b1);
      chk("t4_idle_valid", rsp_valid, 1'b0);

      // 5a: abort in second WAIT
      send_cmd(1'b0, 1'b0, 4'd8, 8'd5, 8'h00);
      cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (strobe) cnt++;
      end
      chk("t5_strobes_before_abort", cnt, 1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t5_abort_idle_busy", busy, 1'b0);
      chk("t5_abort_idle_ready", cmd_ready, 1'b1);
      cnt = 0; rcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (strobe) cnt++;
         if (rsp_valid) rcnt++;
      end
      chk("t5_no_shift_after_abort", cnt, 0);
      chk("t5_no_rsp_after_abort", rcnt, 0);

      // 5b: abort coincident with the last shift
      send_cmd(1'b0, 1'b0, 4'd2, 8'd0, 8'h00);
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      chk("t5b_abort_strobe", strobe, 1'b0);
      chk("t5b_abort_sel", sel, 2'b00);
      @(posedge clk); #1 abort = 1'b0;
      rcnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) rcnt++;
      end
      chk("t5b_no_done", rcnt, 0);
      chk("t5b_idle", busy, 1'b0);

      // 6: async reset mid-run, then a fresh command
      send_cmd(1'b1, 1'b0, 4'd8, 8'd2, 8'h55);
      cnt = 0;
      for (int k = 0; k < 40 && cnt < 3; k++) begin
         @(negedge clk);
         if (strobe) cnt++;
      end
      chk("t6_reached_third_shift", cnt, 3);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t6_async");
      @(posedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      run_cmd(1'b1, 1'b0, 4'd1, 8'd0, 8'h02, 8'h01, rv, ns);
      chk("t6_rsp_cycle", rv, 3);

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
